instr_sequencer: RTL and testbench

- Parametrised next-generation instruction unit for the TinyALU CPU.
- Holds a writable instruction memory and a register file of NUM_REGS operands, and runs a program from pc=0 when triggered.
- Each instruction is dispatched to the memory interface unit (load/store level handshake, terminated by mem_done) or to ALU593 (start/alu_done handshake).
- Adds over the previous unit: a programming port, a HALT instruction, end-of-memory stop, illegal-opcode detection and a handshake timeout watchdog.

---
 rtl/seq_pkg.sv | 46 ++++
 rtl/seq_imem.sv | 30 +++
 rtl/instr_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared state/opcode types and instruction-field geometry for the TinyALU instruction sequencer.
// Field positions are functions of ADDR_W/RSEL_W so every user slices instruction words identically.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_LD_WAIT  = 3'd3,
        ST_ST_WAIT  = 3'd4,
        ST_ALU_WAIT = 3'd5,
        ST_HALTED   = 3'd6,
        ST_ERROR    = 3'd7
    } seq_state_t;

    // ALU codes are passed straight through as the ALU593 op encoding
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_AND   = 4'h2,
        OP_XOR   = 4'h3,
        OP_MUL   = 4'h4,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_HALT  = 4'hF
    } seq_opcode_t;

    localparam int OPC_W = 4;

    function automatic int instr_w(input int addr_w, input int rsel_w);
        return OPC_W + addr_w + 2 * rsel_w;
    endfunction

    function automatic int opc_lsb(input int addr_w, input int rsel_w);
        return addr_w + 2 * rsel_w;
    endfunction

    function automatic int addr_lsb(input int rsel_w);
        return 2 * rsel_w;
    endfunction

    function automatic int ra_lsb(input int rsel_w);
        return rsel_w;
    endfunction

endpackage

// File: rtl/seq_imem.sv
// Single-port instruction RAM: one shared address, write port plus registered read port.
// Read data appears one cycle after re and holds until the next read; no reset on contents.
module seq_imem #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 22,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// TinyALU instruction unit: fetch/decode/dispatch to memory unit or ALU593, 2 cycles per NOP, 3+ per request.
// Requests are level handshakes held until the matching done pulse; a watchdog forces ERROR on a stalled handshake.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int ADDR_W      = 14,
    parameter  int IMEM_DEPTH  = 1024,
    parameter  int NUM_REGS    = 4,
    parameter  int TIMEOUT_CYC = 255,
    localparam int RSEL_W      = $clog2(NUM_REGS),
    localparam int PC_W        = $clog2(IMEM_DEPTH),
    localparam int IW          = instr_w(ADDR_W, RSEL_W)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [IW-1:0]       prog_data,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   data,
    input  logic                alu_done,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                load,
    output logic                store,
    output logic [ADDR_W-1:0]   addr,
    output logic [2*DATA_W-1:0] result,
    output logic                start,
    output logic [3:0]          op,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [PC_W-1:0]     pc
);

    localparam int WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int OPC_LSB  = opc_lsb(ADDR_W, RSEL_W);
    localparam int ADDR_LSB = addr_lsb(RSEL_W);
    localparam int RA_LSB   = ra_lsb(RSEL_W);

    seq_state_t            state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [2*DATA_W-1:0]   res_q;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];

    logic [IW-1:0]         instr;
    logic [3:0]            opc;
    logic [ADDR_W-1:0]     f_addr;
    logic [RSEL_W-1:0]     f_ra;
    logic [RSEL_W-1:0]     f_rb;
    logic                  in_busy;
    logic                  timed_out;
    logic                  last_pc;
    logic                  adv;

    assign opc       = instr[OPC_LSB +: OPC_W];
    assign f_addr    = instr[ADDR_LSB +: ADDR_W];
    assign f_ra      = instr[RA_LSB +: RSEL_W];
    assign f_rb      = instr[0 +: RSEL_W];
    assign in_busy   = state_q inside {ST_FETCH, ST_DECODE, ST_LD_WAIT, ST_ST_WAIT, ST_ALU_WAIT};
    assign timed_out = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign last_pc   = (pc_q == PC_W'(IMEM_DEPTH - 1));

    // The port belongs to the programmer while idle and to the fetch path while running
    seq_imem #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (IW)
    ) u_imem (
        .clk   (clk),
        .we    (prog_we && !in_busy),
        .re    (state_q == ST_FETCH),
        .addr  (in_busy ? pc_q : prog_addr),
        .wdata (prog_data),
        .rdata (instr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wd_d    = wd_q;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (run) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                wd_d = '0;
                case (opc)
                    OP_NOP:                         adv     = 1'b1;
                    OP_LOAD:                        state_d = ST_LD_WAIT;
                    OP_STORE:                       state_d = ST_ST_WAIT;
                    OP_ADD, OP_AND, OP_XOR, OP_MUL: state_d = ST_ALU_WAIT;
                    OP_HALT:                        state_d = ST_HALTED;
                    default:                        state_d = ST_ERROR;
                endcase
            end
            ST_LD_WAIT, ST_ST_WAIT: begin
                if (mem_done)       adv     = 1'b1;
                else if (timed_out) state_d = ST_ERROR;
                else                wd_d    = wd_q + 1'b1;
            end
            ST_ALU_WAIT: begin
                if (alu_done)       adv     = 1'b1;
                else if (timed_out) state_d = ST_ERROR;
                else                wd_d    = wd_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Running off the end of imem is a normal stop, not a wrap
        if (adv) begin
            if (last_pc) begin
                state_d = ST_HALTED;
            end else begin
                state_d = ST_FETCH;
                pc_d    = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            res_q <= '0;
        end else begin
            if (state_q == ST_LD_WAIT && mem_done) begin
                regs_q[f_ra] <= data;
            end
            if (state_q == ST_ALU_WAIT && alu_done) begin
                res_q <= alu_result;
            end
        end
    end

    always_comb begin
        load   = 1'b0;
        store  = 1'b0;
        start  = 1'b0;
        addr   = '0;
        result = '0;
        op     = '0;
        A      = '0;
        B      = '0;
        busy   = in_busy;
        halted = 1'b0;
        error  = 1'b0;
        case (state_q)
            ST_LD_WAIT: begin
                load = 1'b1;
                addr = f_addr;
            end
            ST_ST_WAIT: begin
                store  = 1'b1;
                addr   = f_addr;
                result = res_q;
            end
            ST_ALU_WAIT: begin
                start = 1'b1;
                op    = opc;
                A     = regs_q[f_ra];
                B     = regs_q[f_rb];
            end
            ST_HALTED: halted = 1'b1;
            ST_ERROR:  error  = 1'b1;
            default: ;
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs plus random programs checked by an instruction-level interpreter.
module tb_instr_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16;
    localparam int NREG   = 4;
    localparam int TMO    = 255;
    localparam int PC_W   = 4;
    localparam int IW     = 4 + ADDR_W + 4;

    logic                clk = 1'b0;
    logic                reset_n, run, prog_we, mem_done, alu_done;
    logic [PC_W-1:0]     prog_addr;
    logic [IW-1:0]       prog_data;
    logic [DATA_W-1:0]   data;
    logic [2*DATA_W-1:0] alu_result;
    logic                load, store, start, busy, halted, error;
    logic [ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0] result;
    logic [3:0]          op;
    logic [DATA_W-1:0]   A, B;
    logic [PC_W-1:0]     pc;

    logic [IW-1:0]       prog [DEPTH];
    logic [DATA_W-1:0]   mregs [NREG];
    logic [2*DATA_W-1:0] mres;
    logic [DATA_W-1:0]   ld_force [$];
    int                  fixed_dly = -1;
    int                  n_cmp = 0;
    int                  n_bad = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(DEPTH), .NUM_REGS(NREG), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .mem_done(mem_done), .data(data), .alu_done(alu_done),
        .alu_result(alu_result), .load(load), .store(store), .addr(addr), .result(result),
        .start(start), .op(op), .A(A), .B(B), .busy(busy), .halted(halted), .error(error), .pc(pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [ADDR_W-1:0] a,
                                         input logic [1:0] r1, input logic [1:0] r2);
        return {o, a, r1, r2};
    endfunction

    function automatic logic [15:0] alu_ref(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            4'h1:    return 16'(a) + 16'(b);
            4'h2:    return 16'(a & b);
            4'h3:    return 16'(a ^ b);
            default: return 16'(a) * 16'(b);
        endcase
    endfunction

    function automatic logic [3:0] rand_opc();
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) return 4'h0;
        if (r < 50) return 4'($urandom_range(1, 4));
        if (r < 70) return 4'h8;
        if (r < 85) return 4'h9;
        if (r < 92) return 4'hF;
        r = $urandom_range(0, 7);
        return (r < 3) ? 4'(r + 5) : 4'(r + 7);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic quiet();
        run = 1'b0; prog_we = 1'b0; mem_done = 1'b0; alu_done = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = PC_W'(i); prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
    endtask

    // Interprets prog[] one instruction at a time, playing memory unit and ALU, checking every request.
    task automatic exec_prog();
        int pcm; int d; int ra; int rb;
        bit fin; bit is_mem; bit adv;
        logic [IW-1:0] ins; logic [3:0] o; logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] dv; logic [15:0] rv;
        pcm = 0; fin = 0;
        start_run();
        check("run_clears_flags", 32'({halted, error}), 32'd0);
        while (!fin) begin
            adv = 0;
            check("fetch_pc", 32'(pc), pcm);
            check("fetch_busy", 32'(busy), 32'd1);
            ins = prog[pcm]; o = ins[IW-1 -: 4]; fa = ins[IW-5 -: ADDR_W];
            ra = int'(ins[3:2]); rb = int'(ins[1:0]);
            @(negedge clk);
            check("decode_no_req", 32'({load, store, start}), 32'd0);
            @(negedge clk);
            if (o == 4'h0) begin
                adv = 1;
            end else if (o == 4'hF) begin
                check("halt_flags", 32'({halted, error, busy}), 32'b100);
                check("halt_pc", 32'(pc), pcm);
                fin = 1;
            end else if (o inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9}) begin
                is_mem = (o == 4'h8 || o == 4'h9);
                check("req_load", 32'(load), 32'(o == 4'h8));
                check("req_store", 32'(store), 32'(o == 4'h9));
                check("req_start", 32'(start), 32'(!is_mem));
                if (is_mem) check("req_addr", 32'(addr), 32'(fa));
                if (o == 4'h9) check("req_result", 32'(result), 32'(mres));
                if (!is_mem) begin
                    check("req_op", 32'(op), 32'(o));
                    check("req_A", 32'(A), 32'(mregs[ra]));
                    check("req_B", 32'(B), 32'(mregs[rb]));
                end
                d = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 3);
                for (int k = 0; k < d; k++) begin
                    check("req_held", 32'(is_mem ? (load | store) : start), 32'd1);
                    if (is_mem) alu_done = rbit(); else mem_done = rbit();
                    data = DATA_W'($urandom); alu_result = 16'($urandom);
                    run = ($urandom_range(0, 3) == 0);
                    prog_we = ($urandom_range(0, 3) == 0);
                    prog_addr = PC_W'($urandom); prog_data = IW'($urandom);
                    @(negedge clk);
                    quiet();
                end
                if (d >= TMO) begin
                    check("timeout_flags", 32'({error, load, store, start, busy}), 32'b10000);
                    check("timeout_pc", 32'(pc), pcm);
                    fin = 1;
                end else begin
                    if (ld_force.size() > 0) dv = ld_force.pop_front();
                    else dv = DATA_W'($urandom);
                    rv = alu_ref(o, mregs[ra], mregs[rb]);
                    if (is_mem) begin
                        mem_done = 1'b1; data = dv; alu_done = rbit(); alu_result = 16'($urandom);
                    end else begin
                        alu_done = 1'b1; alu_result = rv; mem_done = rbit(); data = DATA_W'($urandom);
                    end
                    @(negedge clk);
                    quiet();
                    if (o == 4'h8) mregs[ra] = dv;
                    else if (!is_mem) mres = rv;
                    check("req_dropped", 32'({load, store, start}), 32'd0);
                    adv = 1;
                end
            end else begin
                check("illegal_flags", 32'({error, halted, busy, load, store, start}), 32'b100000);
                check("illegal_pc", 32'(pc), pcm);
                fin = 1;
            end
            if (adv) begin
                if (pcm == DEPTH - 1) begin
                    check("end_of_mem_flags", 32'({halted, error, busy}), 32'b100);
                    check("end_of_mem_pc", 32'(pc), pcm);
                    fin = 1;
                end else begin
                    pcm++;
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int cnt;
        reset_n = 1'b0; quiet();
        prog_addr = '0; prog_data = '0; data = '0; alu_result = '0;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mres = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({load, store, start, busy, halted, error}), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_addr_result", 32'({addr, result}), 32'd0);
        check("rst_op_ab", 32'({op, A, B}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        mem_done = 1'b1; alu_done = 1'b1; data = 8'hAA; alu_result = 16'h5555;
        @(negedge clk); quiet();
        @(negedge clk);
        check("idle_dones_ignored", 32'({busy, halted, error, load, store, start}), 32'd0);
        check("idle_dones_pc", 32'(pc), 32'd0);

        // Load/load/add/store/halt
        for (int i = 0; i < DEPTH; i++) prog[i] = mk(4'hF, '0, 2'd0, 2'd0);
        prog[0] = mk(4'h8, 14'h10, 2'd0, 2'd0);
        prog[1] = mk(4'h8, 14'h11, 2'd1, 2'd0);
        prog[2] = mk(4'h1, 14'h0,  2'd0, 2'd1);
        prog[3] = mk(4'h9, 14'h12, 2'd0, 2'd0);
        ld_force.push_back(8'h05); ld_force.push_back(8'h07);
        load_prog(); exec_prog();
        check("p1_halt_pc", 32'(pc), 32'd4);

        // MUL of two 0xFF operands
        prog[0] = mk(4'h8, 14'h20, 2'd2, 2'd0);
        prog[1] = mk(4'h8, 14'h21, 2'd3, 2'd0);
        prog[2] = mk(4'h4, 14'h0,  2'd2, 2'd3);
        prog[3] = mk(4'h9, 14'h22, 2'd0, 2'd0);
        ld_force.push_back(8'hFF); ld_force.push_back(8'hFF);
        load_prog(); exec_prog();

        // Watchdog: done in the last allowed cycle, then never
        prog[0] = mk(4'h8, 14'h30, 2'd1, 2'd0);
        prog[1] = mk(4'hF, 14'h0,  2'd0, 2'd0);
        load_prog();
        fixed_dly = TMO - 1; exec_prog();
        fixed_dly = TMO;     exec_prog();
        fixed_dly = -1;

        // Illegal opcode at pc=2, then stray dones while in ERROR
        prog[0] = mk(4'h0, 14'h0, 2'd0, 2'd0);
        prog[1] = mk(4'h0, 14'h0, 2'd0, 2'd0);
        prog[2] = mk(4'h5, 14'h7, 2'd1, 2'd2);
        load_prog(); exec_prog();
        mem_done = 1'b1; alu_done = 1'b1;
        @(negedge clk); quiet();
        @(negedge clk);
        check("error_dones_ignored", 32'({error, busy, load, store, start}), 32'b10000);

        // Full imem of NOPs with a write attempt mid-run
        for (int i = 0; i < DEPTH; i++) prog[i] = mk(4'h0, '0, 2'd0, 2'd0);
        load_prog();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        cnt = 0;
        while (!halted && cnt < 100) begin
            if (cnt == 3) begin
                prog_we = 1'b1; prog_addr = 4'd10; prog_data = mk(4'hF, '0, 2'd0, 2'd0);
            end
            @(negedge clk);
            prog_we = 1'b0;
            cnt++;
        end
        check("nop_run_cycles", cnt, 32'd32);
        check("nop_run_pc", 32'(pc), 32'd15);
        exec_prog();

        // Asynchronous reset in the middle of ALU_WAIT
        prog[0] = mk(4'h8, 14'h40, 2'd0, 2'd0);
        prog[1] = mk(4'h1, 14'h0,  2'd0, 2'd0);
        prog[2] = mk(4'hF, 14'h0,  2'd0, 2'd0);
        load_prog(); start_run();
        cnt = 0;
        while (!load && cnt < 10) begin @(negedge clk); cnt++; end
        check("rst_load_seen", 32'(load), 32'd1);
        mem_done = 1'b1; data = 8'h33;
        @(negedge clk); quiet();
        cnt = 0;
        while (!start && cnt < 10) begin @(negedge clk); cnt++; end
        check("rst_start_seen", 32'(start), 32'd1);
        check("rst_A_before", 32'(A), 32'h33);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_ctl", 32'({start, busy}), 32'd0);
        check("rst_async_ab", 32'({A, B}), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mres = '0;
        @(negedge clk);
        check("rst_idle_flags", 32'({busy, halted, error}), 32'd0);
        check("rst_idle_pc", 32'(pc), 32'd0);

        // Registers and result register must read back cleared
        prog[0] = mk(4'h1, 14'h0,  2'd0, 2'd1);
        prog[1] = mk(4'h9, 14'h50, 2'd0, 2'd0);
        prog[2] = mk(4'hF, 14'h0,  2'd0, 2'd0);
        load_prog(); exec_prog();

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DEPTH; i++)
                prog[i] = mk(rand_opc(), ADDR_W'($urandom), 2'($urandom), 2'($urandom));
            load_prog(); exec_prog();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
